muldiv_seq: RTL

MULDIV_SEQ -- requirements
Module: muldiv_seq

---
 rtl/muldiv_pkg.sv | 22 ++
 rtl/muldiv_wdog.sv | 28 ++
 rtl/muldiv_seq.sv | 132 +++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer: state and op encodings
// plus watchdog sizing.
package muldiv_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StStart = 3'd1,
        StWait  = 3'd2,
        StLoad  = 3'd3,
        StDone  = 3'd4,
        StExc   = 3'd5
    } state_e;

    typedef enum logic {
        OpDiv  = 1'b0,
        OpMult = 1'b1
    } op_e;

    localparam int unsigned WdogWidth      = 6;
    localparam int unsigned WdogMaxDefault = 63;

endpackage

// File: rtl/muldiv_wdog.sv
// Saturating watchdog counter for the WAIT phase; expired flags the terminal count.
module muldiv_wdog
    import muldiv_pkg::*;
#(
    parameter int unsigned WDOG_MAX = WdogMaxDefault
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [WdogWidth-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + WdogWidth'(1);
        end
    end

    assign expired = (32'(count) == WDOG_MAX);

endmodule

// File: rtl/muldiv_seq.sv
// Sequencer that launches the external mult/div units, waits for completion
// under a watchdog, and loads HI/LO or raises an exception.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int unsigned WDOG_MAX = WdogMaxDefault
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_mult,
    input  logic        start_div,
    input  logic [31:0] op_b,
    input  logic        mult_stop,
    input  logic        div_stop,
    input  logic        div_zero,
    output logic        mult_control,
    output logic        div_control,
    output logic        HiLo_load,
    output logic        sel_mux_hi,
    output logic        sel_mux_lo,
    output logic        busy,
    output logic        done,
    output logic        div_zero_exc,
    output logic        timeout_exc
);

    state_e state;
    op_e    op;
    logic   wdog_expired;

    // Counter is held clear outside WAIT so it starts from zero on every entry.
    muldiv_wdog #(
        .WDOG_MAX (WDOG_MAX)
    ) u_wdog (
        .clk     (clk),
        .reset   (reset),
        .clr     (state != StWait),
        .en      (state == StWait),
        .expired (wdog_expired)
    );

    // Outputs are registered alongside the state they belong to.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= StIdle;
            op           <= OpDiv;
            mult_control <= 1'b0;
            div_control  <= 1'b0;
            HiLo_load    <= 1'b0;
            sel_mux_hi   <= 1'b0;
            sel_mux_lo   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            div_zero_exc <= 1'b0;
            timeout_exc  <= 1'b0;
        end else begin
            mult_control <= 1'b0;
            div_control  <= 1'b0;
            HiLo_load    <= 1'b0;
            sel_mux_hi   <= 1'b0;
            sel_mux_lo   <= 1'b0;
            done         <= 1'b0;
            div_zero_exc <= 1'b0;
            timeout_exc  <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start_mult) begin
                        op           <= OpMult;
                        state        <= StStart;
                        busy         <= 1'b1;
                        mult_control <= 1'b1;
                    end else if (start_div) begin
                        op   <= OpDiv;
                        busy <= 1'b1;
                        if (op_b == '0) begin
                            state        <= StExc;
                            div_zero_exc <= 1'b1;
                        end else begin
                            state       <= StStart;
                            div_control <= 1'b1;
                        end
                    end
                end
                StStart: begin
                    state <= StWait;
                end
                StWait: begin
                    // A completion arriving on the terminal count beats the timeout.
                    if (op == OpMult) begin
                        if (mult_stop) begin
                            state      <= StLoad;
                            HiLo_load  <= 1'b1;
                            sel_mux_hi <= 1'b1;
                            sel_mux_lo <= 1'b1;
                        end else if (wdog_expired) begin
                            state       <= StExc;
                            timeout_exc <= 1'b1;
                        end
                    end else begin
                        if (div_zero) begin
                            state        <= StExc;
                            div_zero_exc <= 1'b1;
                        end else if (div_stop) begin
                            state     <= StLoad;
                            HiLo_load <= 1'b1;
                        end else if (wdog_expired) begin
                            state       <= StExc;
                            timeout_exc <= 1'b1;
                        end
                    end
                end
                StLoad: begin
                    state <= StDone;
                    done  <= 1'b1;
                end
                StDone: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
                StExc: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
